dda_tracer: RTL and testbench

Parametrised DDA raycaster that traces one frame of wall columns per `start` request and streams per-column `{column, side, height}` records to the trace buffer. It runs during VBLANK between the player/view-vector registers and the trace buffer, reading the map ROM one cell per step. Compared with the fixed 640/512/16×16 tracer, it generalises:
- screen, trace and map sizes;
- fixed-point format;
- the per-ray step budget.

It also adds a start/done frame handshake, output backpressure, input latching and explicit miss handling.

---
 rtl/dda_tracer.sv | 251 +++++++++++++++++++++++++
 tb/tb_dda_tracer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dda_tracer.sv
// DDA raycaster: one frame of {column, side, height} records per start request.
// Define DDA_TRACER_WALLID_EN to add the wall_id output (map value of the hit cell).
module dda_tracer #(
  parameter int QM         = 6,
  parameter int QN         = 10,
  parameter int COLS       = 640,
  parameter int TRACE_COLS = 512,
  parameter int MAP_BITS   = 4,
  parameter int HEIGHT_MAX = 240,
  parameter int MAX_STEPS  = 32,
  localparam int W  = QM + QN,
  localparam int CW = $clog2(COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [W-1:0]        player_x,
  input  logic [W-1:0]        player_y,
  input  logic [W-1:0]        facing_x,
  input  logic [W-1:0]        facing_y,
  input  logic [W-1:0]        vplane_x,
  input  logic [W-1:0]        vplane_y,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       column,
  output logic                side,
  output logic [7:0]          height,
  output logic [MAP_BITS-1:0] map_col,
  output logic [MAP_BITS-1:0] map_row,
  input  logic [1:0]          map_val
`ifdef DDA_TRACER_WALLID_EN
  ,
  output logic [1:0]          wall_id
`endif
);

  localparam int MARGIN = (COLS - TRACE_COLS) / 2;
  localparam int TSH    = $clog2(TRACE_COLS) - 1;
  localparam int SW     = $clog2(MAX_STEPS + 1);
  localparam int TW     = W + SW + 1;
  localparam logic [W-1:0]        MAXPOS      = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        ONE         = W'(1) << QN;
  localparam logic [2*W:0]        ONE2        = (2*W+1)'(1) << (2*QN);
  localparam logic [CW-1:0]       LAST_LCLEAR = CW'(MARGIN - 1);
  localparam logic [CW-1:0]       LAST_TRACE  = CW'(MARGIN + TRACE_COLS - 1);
  localparam logic [CW-1:0]       LAST_COL    = CW'(COLS - 1);
  localparam logic [MAP_BITS-1:0] MAP_MAX     = '1;
  localparam logic [SW-1:0]       STEP_LIMIT  = SW'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, LCLEAR, INIT, STEP, CHECK, EMIT, RCLEAR, FINISH} stateT;
  stateT state, nextState;

  logic [W-1:0]          px, py, distX, distY;
  logic signed [W-1:0]   rayX, rayY, incX, incY;
  logic [TW-1:0]         trackX, trackY;
  logic                  blkX, blkY, wrapped;
  logic [SW-1:0]         stepCnt;
  logic [MAP_BITS-1:0]   mapX, mapY;
  logic [CW-1:0]         colReg;
  logic                  sideReg, outValid, busyReg, doneReg;
  logic [7:0]            heightReg;

  logic [W-1:0]          absX, absY, recipX, recipY, fracX, fracY, partialX, partialY;
  logic [2*W-1:0]        prodX, prodY;
  logic [TW-1:0]         trackInitX, trackInitY, hitDiff;
  logic                  blkInitX, blkInitY, stepX, accept, hitNow, missNow;
  logic [W-1:0]          hitDist, recipDist;
  logic [W+7:0]          heightProd;
  logic [7:0]            heightCalc;

  // Rounded 1/a in the same fixed-point format, saturating at the largest positive value.
  function automatic logic [W-1:0] recip(input logic [W-1:0] a);
    logic [2*W:0] q;
    if (a == '0) return MAXPOS;
    q = (ONE2 + (2*W+1)'(a >> 1)) / (2*W+1)'(a);
    return (q > (2*W+1)'(MAXPOS)) ? MAXPOS : q[W-1:0];
  endfunction

  assign accept = outValid && out_ready;

  always_comb begin
    absX       = rayX[W-1] ? W'(-rayX) : W'(rayX);
    absY       = rayY[W-1] ? W'(-rayY) : W'(rayY);
    recipX     = recip(absX);
    recipY     = recip(absY);
    fracX      = {{QM{1'b0}}, px[QN-1:0]};
    fracY      = {{QM{1'b0}}, py[QN-1:0]};
    partialX   = (rayX[W-1] || rayX == '0) ? fracX : ONE - fracX;
    partialY   = (rayY[W-1] || rayY == '0) ? fracY : ONE - fracY;
    prodX      = (2*W)'(recipX) * (2*W)'(partialX);
    prodY      = (2*W)'(recipY) * (2*W)'(partialY);
    trackInitX = TW'(W'(prodX >> QN));
    trackInitY = TW'(W'(prodY >> QN));
    blkInitX   = (recipX == MAXPOS) || recipX[W-2];
    blkInitY   = (recipY == MAXPOS) || recipY[W-2];
    stepX      = blkY || (!blkX && (trackX < trackY));
    // track has already been advanced past the hit face, so back off one step
    hitDiff    = sideReg ? (trackY - TW'(distY)) : (trackX - TW'(distX));
    hitDist    = (hitDiff > TW'(MAXPOS)) ? MAXPOS : W'(hitDiff);
    recipDist  = recip(hitDist);
    heightProd = (W+8)'(HEIGHT_MAX) * (W+8)'(recipDist);
    heightCalc = (recipDist > ONE) ? 8'(HEIGHT_MAX) : 8'(heightProd >> QN);
    hitNow     = (state == CHECK) && !wrapped && (map_val != 2'd0);
    missNow    = (state == CHECK) && (wrapped || (map_val == 2'd0 && stepCnt == STEP_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (start) nextState = (MARGIN == 0) ? INIT : LCLEAR;
      LCLEAR: if (accept && colReg == LAST_LCLEAR) nextState = INIT;
      INIT:   nextState = (blkInitX && blkInitY) ? EMIT : STEP;
      STEP:   nextState = CHECK;
      CHECK:  nextState = (hitNow || missNow) ? EMIT : STEP;
      EMIT:   if (accept) begin
                if (colReg == LAST_TRACE) nextState = (MARGIN == 0) ? FINISH : RCLEAR;
                else                      nextState = INIT;
              end
      RCLEAR: if (accept && colReg == LAST_COL) nextState = FINISH;
      FINISH: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: vector latching, DDA stepping and the registered output record.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0; busyReg <= 1'b0; doneReg <= 1'b0;
      colReg <= '0; sideReg <= 1'b0; heightReg <= '0;
      mapX <= '0; mapY <= '0; stepCnt <= '0; wrapped <= 1'b0;
      px <= '0; py <= '0; rayX <= '0; rayY <= '0; incX <= '0; incY <= '0;
      trackX <= '0; trackY <= '0; distX <= '0; distY <= '0; blkX <= 1'b0; blkY <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: if (start) begin
          px <= player_x;
          py <= player_y;
          rayX <= $signed(facing_x) - $signed(vplane_x);
          rayY <= $signed(facing_y) - $signed(vplane_y);
          incX <= $signed(vplane_x) >>> TSH;
          incY <= $signed(vplane_y) >>> TSH;
          colReg <= '0;
          busyReg <= 1'b1;
          sideReg <= 1'b0;
          heightReg <= '0;
          outValid <= (MARGIN != 0);
        end
        LCLEAR: if (accept) begin
          if (colReg == LAST_LCLEAR) outValid <= 1'b0;
          colReg <= colReg + CW'(1);
        end
        INIT: begin
          mapX <= MAP_BITS'(px >> QN);
          mapY <= MAP_BITS'(py >> QN);
          trackX <= trackInitX;
          trackY <= trackInitY;
          distX <= recipX;
          distY <= recipY;
          blkX <= blkInitX;
          blkY <= blkInitY;
          stepCnt <= '0;
          wrapped <= 1'b0;
          if (blkInitX && blkInitY) begin
            heightReg <= '0;
            outValid <= 1'b1;
          end
        end
        STEP: begin
          if (stepX) begin
            mapX <= rayX[W-1] ? mapX - MAP_BITS'(1) : mapX + MAP_BITS'(1);
            wrapped <= rayX[W-1] ? (mapX == '0) : (mapX == MAP_MAX);
            trackX <= trackX + TW'(distX);
            sideReg <= 1'b0;
          end else begin
            mapY <= rayY[W-1] ? mapY - MAP_BITS'(1) : mapY + MAP_BITS'(1);
            wrapped <= rayY[W-1] ? (mapY == '0) : (mapY == MAP_MAX);
            trackY <= trackY + TW'(distY);
            sideReg <= 1'b1;
          end
          stepCnt <= stepCnt + SW'(1);
        end
        CHECK: begin
          if (missNow) begin
            heightReg <= '0;
            outValid <= 1'b1;
          end else if (hitNow) begin
            heightReg <= heightCalc;
            outValid <= 1'b1;
          end
        end
        EMIT: if (accept) begin
          colReg <= colReg + CW'(1);
          if (colReg == LAST_TRACE) begin
            if (MARGIN == 0) begin
              outValid <= 1'b0;
              doneReg <= 1'b1;
            end else begin
              heightReg <= '0;
              sideReg <= 1'b0;
            end
          end else begin
            outValid <= 1'b0;
            rayX <= rayX + incX;
            rayY <= rayY + incY;
          end
        end
        RCLEAR: if (accept) begin
          if (colReg == LAST_COL) begin
            outValid <= 1'b0;
            doneReg <= 1'b1;
          end else begin
            colReg <= colReg + CW'(1);
          end
        end
        FINISH: busyReg <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef DDA_TRACER_WALLID_EN
  logic [1:0] wallId;

  // Holds the hit cell value with its record; any other record carries 0.
  always_ff @(posedge clk) begin
    if (reset)                                        wallId <= 2'd0;
    else if (state == CHECK)                          wallId <= wrapped ? 2'd0 : map_val;
    else if (accept || state == IDLE || state == INIT) wallId <= 2'd0;
  end

  assign wall_id = wallId;
`endif

  assign busy      = busyReg;
  assign done      = doneReg;
  assign out_valid = outValid;
  assign column    = colReg;
  assign side      = sideReg;
  assign height    = heightReg;
  assign map_col   = mapX;
  assign map_row   = mapY;

endmodule

// File: tb/tb_dda_tracer.sv
// Scoreboard bench for dda_tracer: default 640-column instance plus a 320-column, 32x32-map instance.
`timescale 1ns/1ps
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s got=%0d exp=%0d", tag, (obs), (exp)); end end

module tb_dda_tracer;
  localparam int W = 16;
  localparam int BUDGET = 50000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, outReady;
  logic [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic busy, done, outValid, side;
  logic [9:0] column;
  logic [7:0] height;
  logic [3:0] mapCol, mapRow;
  logic [1:0] mapVal;
  bit wallOn;

  logic start2, ready2, busy2, done2, valid2, side2;
  logic [W-1:0] player2, facing2X, facing2Y, vplane2X, vplane2Y;
  logic [8:0] column2;
  logic [7:0] height2;
  logic [4:0] mapCol2, mapRow2;
  logic [1:0] mapVal2;

`ifdef DDA_TRACER_WALLID_EN
  logic [1:0] wallId, wallId2;
`endif

  assign mapVal  = (wallOn && mapCol == 4'd10) ? 2'd2 : 2'd0;
  assign mapVal2 = (mapCol2 == 5'd20) ? 2'd2 : 2'd0;

  dda_tracer dut (
    .clk(clk), .reset(reset), .start(start),
    .player_x(playerX), .player_y(playerY),
    .facing_x(facingX), .facing_y(facingY),
    .vplane_x(vplaneX), .vplane_y(vplaneY),
    .busy(busy), .done(done), .out_valid(outValid), .out_ready(outReady),
    .column(column), .side(side), .height(height),
    .map_col(mapCol), .map_row(mapRow), .map_val(mapVal)
`ifdef DDA_TRACER_WALLID_EN
    , .wall_id(wallId)
`endif
  );

  dda_tracer #(.COLS(320), .TRACE_COLS(256), .MAP_BITS(5)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .player_x(player2), .player_y(player2),
    .facing_x(facing2X), .facing_y(facing2Y),
    .vplane_x(vplane2X), .vplane_y(vplane2Y),
    .busy(busy2), .done(done2), .out_valid(valid2), .out_ready(ready2),
    .column(column2), .side(side2), .height(height2),
    .map_col(mapCol2), .map_row(mapRow2), .map_val(mapVal2)
`ifdef DDA_TRACER_WALLID_EN
    , .wall_id(wallId2)
`endif
  );

  typedef struct { int col; int height; bit chkSide; int wid; } expT;
  expT sbQ[$];
  expT e;
  int total = 0, bad = 0;
  int doneCount = 0, recCount = 0, gap = 0;
  int done2Count = 0, exp2Col = 0;
  bit checkLatency = 1'b0, stalledPrev = 1'b0;
  logic [18:0] prevRec;

  // Main-instance monitor: pops one expected record per accepted output.
  always @(negedge clk) begin
    if (reset) begin
      stalledPrev = 1'b0;
      gap = 0;
    end else begin
      gap++;
      if (done) doneCount++;
      if (stalledPrev) `CHK("stall_hold", {column, side, height}, prevRec)
      if (outValid && outReady) begin
        recCount++;
        total++;
        assert (sbQ.size() > 0) else begin bad++; $error("FAIL sb_extra got=%0d exp=%0d", column, -1); end
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          `CHK("column", column, e.col)
          `CHK("height", height, e.height)
          if (e.chkSide) `CHK("side", side, 1'b0)
`ifdef DDA_TRACER_WALLID_EN
          `CHK("wall_id", wallId, e.wid)
`endif
        end
        if (checkLatency) begin
          total++;
          assert (gap <= 66) else begin bad++; $error("FAIL latency got=%0d exp=<=%0d", gap, 66); end
        end
        gap = 0;
      end
      stalledPrev = outValid && !outReady;
      prevRec = {column, side, height};
    end
  end

  // Second instance: wall at x=20, player 16.5 -> perpendicular distance 3.5 on every traced ray.
  always @(negedge clk) begin
    if (!reset) begin
      if (done2) done2Count++;
      if (valid2) begin
        `CHK("d2_column", column2, exp2Col)
        `CHK("d2_height", height2, (exp2Col >= 32 && exp2Col < 288) ? 68 : 0)
`ifdef DDA_TRACER_WALLID_EN
        `CHK("d2_wall_id", wallId2, (exp2Col >= 32 && exp2Col < 288) ? 2 : 0)
`endif
        exp2Col++;
      end
    end
  end

  task automatic setView();
    playerX = 16'd8704;  playerY = 16'd8704;
    facingX = 16'd1024;  facingY = 16'd0;
    vplaneX = 16'd0;     vplaneY = 16'd676;
  endtask

  task automatic pushExpected(input bit wallMode);
    sbQ.delete();
    for (int c = 0; c < 640; c++) begin
      bit traced;
      traced = (c >= 64 && c < 576);
      sbQ.push_back('{c, (traced && wallMode) ? 160 : 0, wallMode || !traced,
                      (traced && wallMode) ? 2 : 0});
    end
  endtask

  task automatic checkOutput(input int cyc);
    total++;
    assert (cyc < BUDGET) else begin bad++; $error("FAIL frame_timeout got=%0d exp=<%0d", cyc, BUDGET); end
    `CHK("rec_count", recCount, 640)
    `CHK("done_count", doneCount, 1)
    `CHK("sb_left", sbQ.size(), 0)
    `CHK("busy_idle", busy, 1'b0)
    `CHK("valid_idle", outValid, 1'b0)
  endtask

  // One frame; vectors are scrambled once the frame is running to show they were latched.
  task automatic applyStimulus(input bit wallMode, input bit randReady, input bit latency);
    int cyc;
    wallOn = wallMode;
    checkLatency = latency;
    pushExpected(wallMode);
    doneCount = 0;
    recCount = 0;
    gap = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    playerX = 16'd0; facingX = 16'd0; vplaneY = 16'hFFFF;
    cyc = 0;
    while (busy && cyc < BUDGET) begin
      @(posedge clk); #1;
      if (randReady) outReady = 1'($urandom_range(0, 1));
      cyc++;
    end
    outReady = 1'b1;
    setView();
    repeat (4) @(posedge clk);
    #1;
    checkOutput(cyc);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; outReady = 1'b1; wallOn = 1'b0;
    start2 = 1'b0; ready2 = 1'b1;
    player2 = 16'd16896; facing2X = 16'd1024; facing2Y = 16'd0;
    vplane2X = 16'd0; vplane2Y = 16'd676;
    setView();
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_valid", outValid, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_column", column, 0)
    `CHK("rst_side", side, 1'b0)
    `CHK("rst_height", height, 0)
    `CHK("rst_map_col", mapCol, 0)
    `CHK("rst_map_row", mapRow, 0)
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] wall at x=10, ready high");
    applyStimulus(1'b1, 1'b0, 1'b0);
    $display("[TB] empty map, every ray misses");
    applyStimulus(1'b0, 1'b0, 1'b1);
    $display("[TB] wall map, random backpressure");
    applyStimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] reset at column 300");
    wallOn = 1'b1;
    pushExpected(1'b1);
    doneCount = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(outValid && column == 10'd300) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    assert (cyc < BUDGET) else begin bad++; $error("FAIL reach_col300 got=%0d exp=<%0d", cyc, BUDGET); end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    `CHK("midrst_busy", busy, 1'b0)
    `CHK("midrst_valid", outValid, 1'b0)
    `CHK("midrst_column", column, 0)
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    `CHK("midrst_no_done", doneCount, 0)
    `CHK("midrst_idle", busy, 1'b0)
    applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] 320-column instance");
    exp2Col = 0;
    done2Count = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    assert (cyc < BUDGET) else begin bad++; $error("FAIL d2_timeout got=%0d exp=<%0d", cyc, BUDGET); end
    `CHK("d2_count", exp2Col, 320)
    `CHK("d2_done", done2Count, 1)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
